// File: rtl/sys_defs.sv
// Shared types for the execute-stage multiplier: data word, multiply func
// encoding and the payload carried between pipeline stages.
package sys_defs;

    typedef logic [31:0] DATA;

    typedef enum logic [1:0] {
        M_MUL    = 2'h0,
        M_MULH   = 2'h1,
        M_MULHSU = 2'h2,
        M_MULHU  = 2'h3
    } MULT_FUNC;

    // a is the multiplicand pre-shifted to this stage's weight; b is the
    // multiplier pre-shifted so its low chunk is the one this stage consumes.
    typedef struct packed {
        MULT_FUNC    func;
        logic [63:0] sum;
        logic [63:0] a;
        logic [63:0] b;
    } mult_pl_t;

    function automatic logic [63:0] ext32(input DATA v, input logic sgn);
        return {{32{sgn & v[31]}}, v};
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiplier pipeline stage: adds a * b[W-1:0] to the running sum and
// hands on the operands shifted by W for the next stage.
module mult_stage
    import sys_defs::*;
#(
    parameter int W = 16
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     vld_in,
    input  mult_pl_t pl_in,
    output logic     vld_out,
    output mult_pl_t pl_out
);

    logic [63:0] b_chunk;
    mult_pl_t    pl_nxt;

    always_comb begin
        b_chunk     = 64'(pl_in.b[W-1:0]);
        pl_nxt.func = pl_in.func;
        pl_nxt.sum  = pl_in.sum + pl_in.a * b_chunk;
        pl_nxt.a    = pl_in.a << W;
        pl_nxt.b    = pl_in.b >> W;
    end

    // Payload loads only with a valid op, so bubbles leave the last
    // completed value in place for the output slice to hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_out <= 1'b0;
            pl_out  <= '0;
        end else begin
            vld_out <= vld_in;
            if (vld_in)
                pl_out <= pl_nxt;
        end
    end

endmodule

// File: rtl/mult.sv
// Pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU), NUM_STAGES deep.
// Define MULT_OUTPUT_REG_EN to add one output register (latency +1).
module mult
    import sys_defs::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     start,
    input  DATA      rs1,
    input  DATA      rs2,
    input  MULT_FUNC func,
    output DATA      result,
    output logic     done
);

    localparam int W = 64 / NUM_STAGES;

    if (NUM_STAGES != 1 && NUM_STAGES != 2 && NUM_STAGES != 4 && NUM_STAGES != 8) begin : g_bad_cfg
        $error("mult: NUM_STAGES must be 1, 2, 4 or 8");
    end

    logic [NUM_STAGES:0] vld_pipe;
    mult_pl_t            pl_pipe [0:NUM_STAGES];

    // Only MULHU treats rs1 as unsigned; rs2 is signed only for MUL/MULH.
    logic sgn1, sgn2;
    assign sgn1 = (func != M_MULHU);
    assign sgn2 = (func == M_MUL) || (func == M_MULH);

    assign vld_pipe[0]     = start;
    assign pl_pipe[0].func = func;
    assign pl_pipe[0].sum  = 64'h0;
    assign pl_pipe[0].a    = ext32(rs1, sgn1);
    assign pl_pipe[0].b    = ext32(rs2, sgn2);

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        mult_stage #(.W(W)) u_stage (
            .clock   (clock),
            .reset   (reset),
            .vld_in  (vld_pipe[k]),
            .pl_in   (pl_pipe[k]),
            .vld_out (vld_pipe[k+1]),
            .pl_out  (pl_pipe[k+1])
        );
    end

    mult_pl_t fin;
    DATA      fin_slice;
    logic     unused_tail;

    assign fin         = pl_pipe[NUM_STAGES];
    assign fin_slice   = (fin.func == M_MUL) ? fin.sum[31:0] : fin.sum[63:32];
    assign unused_tail = ^{fin.a, fin.b};

`ifdef MULT_OUTPUT_REG_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= vld_pipe[NUM_STAGES];
            if (vld_pipe[NUM_STAGES])
                result <= fin_slice;
        end
    end
`else
    assign result = fin_slice;
    assign done   = vld_pipe[NUM_STAGES];
`endif

endmodule

// File: tb/tb_mult.sv
// Directed/table-driven bench for mult: vector table, back-to-back stream
// against a 64-bit behavioural model, and reset-while-busy sequence.
module tb_mult;
    import sys_defs::*;

    localparam int NS = 4;
`ifdef MULT_OUTPUT_REG_EN
    localparam int LAT = NS + 1;
`else
    localparam int LAT = NS;
`endif
    localparam int NR = 40;

    logic     clock = 1'b0;
    logic     reset;
    logic     start;
    DATA      rs1, rs2;
    MULT_FUNC func;
    DATA      result;
    logic     done;

    mult #(.NUM_STAGES(NS)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .rs1    (rs1),
        .rs2    (rs2),
        .func   (func),
        .result (result),
        .done   (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        MULT_FUNC f;
        DATA      a;
        DATA      b;
        DATA      exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input DATA act, input DATA exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic DATA model(input MULT_FUNC f, input DATA a, input DATA b);
        logic [63:0] ea, eb, p;
        ea = (f == M_MULHU) ? {32'h0, a} : {{32{a[31]}}, a};
        eb = (f == M_MUL || f == M_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (f == M_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic drive(input logic s, input MULT_FUNC f, input DATA a, input DATA b);
        start = s;
        func  = f;
        rs1   = a;
        rs2   = b;
    endtask

    // Issue one op at the current negedge, check it lands exactly LAT cycles
    // later, then check done drops and result holds.
    task automatic run_one(input string name, input MULT_FUNC f, input DATA a, input DATA b,
                           input DATA exp);
        drive(1'b1, f, a, b);
        @(negedge clock);
        drive(1'b0, M_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
        for (int c = 1; c < LAT; c++) begin
            if (c == LAT - 1)
                chk({name, "_early_done"}, 32'(done), 32'd0);
            @(negedge clock);
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_result"}, result, exp);
        @(negedge clock);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_hold"}, result, exp);
    endtask

    vec_t     vecs[$];
    MULT_FUNC rf[NR];
    DATA      ra[NR], rb[NR], rexp[NR];

    initial begin
        int late_done;

        vecs.push_back('{M_MUL,    32'd0,         32'd0,         32'd0});
        vecs.push_back('{M_MUL,    32'd1,         32'd0,         32'd0});
        vecs.push_back('{M_MUL,    32'd0,         32'd1,         32'd0});
        vecs.push_back('{M_MUL,    32'd3,         32'd4,         32'd12});
        vecs.push_back('{M_MUL,    32'd2,         32'd15,        32'd30});
        vecs.push_back('{M_MUL,    32'd15,        32'd2,         32'd30});
        vecs.push_back('{M_MUL,    32'd30,        32'd30,        32'd900});
        vecs.push_back('{M_MUL,    32'hFF123456,  32'hFFFFF888,  32'hF0091DB0});
        vecs.push_back('{M_MULH,   32'hFF123456,  32'hFFFFF888,  32'h00000006});
        vecs.push_back('{M_MULHU,  32'hFF123456,  32'hFFFFF888,  32'hFF122CE4});
        vecs.push_back('{M_MULHSU, 32'hFF123456,  32'hFFFFF888,  32'hFF12345C});
        vecs.push_back('{M_MUL,    32'hC0000000,  32'd4,         32'd0});
        vecs.push_back('{M_MULH,   32'hC0000000,  32'd4,         32'hFFFFFFFF});
        vecs.push_back('{M_MULHU,  32'hC0000000,  32'd4,         32'd3});
        vecs.push_back('{M_MULHSU, 32'hC0000000,  32'd4,         32'hFFFFFFFF});
        vecs.push_back('{M_MUL,    32'd4,         32'hC0000000,  32'd0});
        vecs.push_back('{M_MULH,   32'd4,         32'hC0000000,  32'hFFFFFFFF});
        vecs.push_back('{M_MULHU,  32'd4,         32'hC0000000,  32'd3});
        vecs.push_back('{M_MULHSU, 32'd4,         32'hC0000000,  32'd3});
        vecs.push_back('{M_MULH,   32'h80000000,  32'h80000000,  32'h40000000});
        vecs.push_back('{M_MULHU,  32'hFFFFFFFF,  32'd0,         32'd0});

        reset = 1'b0;
        drive(1'b0, M_MUL, 32'd0, 32'd0);
        repeat (2) @(negedge clock);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++)
            run_one($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Back-to-back stream, 10 ops per func, expected from the model.
        for (int i = 0; i < NR; i++) begin
            rf[i]   = MULT_FUNC'(i / 10);
            ra[i]   = $urandom;
            rb[i]   = $urandom;
            rexp[i] = model(rf[i], ra[i], rb[i]);
        end
        for (int cyc = 0; cyc <= NR + LAT; cyc++) begin
            if (cyc >= LAT && cyc - LAT < NR) begin
                chk($sformatf("b2b%0d_done", cyc - LAT), 32'(done), 32'd1);
                chk($sformatf("b2b%0d_result", cyc - LAT), result, rexp[cyc - LAT]);
            end else if (cyc == NR + LAT) begin
                chk("b2b_tail_done", 32'(done), 32'd0);
            end
            if (cyc < NR)
                drive(1'b1, rf[cyc], ra[cyc], rb[cyc]);
            else
                drive(1'b0, M_MUL, 32'd0, 32'd0);
            @(negedge clock);
        end

        // Two ops in flight, then asynchronous reset mid-cycle.
        drive(1'b1, M_MUL, 32'd7, 32'd9);
        @(negedge clock);
        drive(1'b1, M_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clock);
        drive(1'b0, M_MUL, 32'd0, 32'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_result", result, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        late_done = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clock);
            if (done === 1'b1)
                late_done++;
        end
        chk("no_done_after_rst", 32'(late_done), 32'd0);
        run_one("post_rst", M_MUL, 32'd3, 32'd4, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult.md
Name: mult

Overview:
- Pipelined 32x32 integer multiplier implementing the RISC-V M-extension multiply group: MUL, MULH, MULHSU, MULHU.
- Sits in the execute stage as the multi-cycle functional unit alongside the ALU.
- Accepts one operation per cycle via a start pulse and returns a 32-bit result with a one-cycle done pulse a fixed number of cycles later.

Parameters:
- NUM_STAGES, 4, pipeline depth in cycles; must be one of 1, 2, 4, 8. Each stage consumes 64/NUM_STAGES multiplier bits.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  launch an operation with the current rs1/rs2/func.
- rs1  input  32 (DATA)  multiplicand.
- rs2  input  32 (DATA)  multiplier.
- func  input  MULT_FUNC (2)  operation select.
- result  output  32 (DATA)  product slice; valid while done=1.
- done  output  1  one-cycle pulse marking a completed operation.

Behaviour:
- Operand extension to 64 bits, applied at the launch cycle:
  - MUL, MULH: rs1 and rs2 both sign-extended.
  - MULHU: rs1 and rs2 both zero-extended.
  - MULHSU: rs1 sign-extended, rs2 zero-extended.
- Product is computed modulo 2^64 from the extended operands.
- Output slice: MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Pipeline stages:
  - Stage k adds (extended rs1 << k*W) * (extended rs2 bits [k*W +: W]) to a running 64-bit partial sum, where W = 64/NUM_STAGES.
  - Each stage carries its own valid bit, func and shifted operands.
- Latency:
  - start sampled high at rising edge N causes done=1 and a valid result during the cycle after edge N+NUM_STAGES-1. For example, with NUM_STAGES=4, start captured at edge 0 produces done high after edge 3.
  - Operations complete in issue order.
- Throughput:
  - One new operation per cycle; back-to-back starts yield back-to-back done pulses.
  - No stall or ready input. The consumer must accept every result.
- done is high for exactly one cycle per started operation.
- result holds the last completed value while done=0. It is 0 after reset until the first completion.
- start=0: no operation enters; a bubble propagates. Operand and func inputs are ignored when start=0.
- Reset (reset=0, asynchronous): clears all stage valid bits, partial sums and result to 0; done=0 immediately. In-flight operations are discarded and never produce done. Operation resumes on the first edge after reset deasserts.
- Boundary cases:
  - A zero operand yields a result of 0.
  - MULH of 0x80000000 * 0x80000000 gives 0x40000000.
  - All slices wrap modulo 2^64 with no overflow flag.

Optional Feature:
- Macro: MULT_OUTPUT_REG_EN.
- When defined: result and done pass through one extra output register; latency becomes NUM_STAGES+1 cycles. Reset and throughput rules are unchanged.
- When undefined: result and done are driven directly from the final stage, giving NUM_STAGES latency.

Decomposition:
- Shared package (sys_defs): DATA (32-bit logic); MULT_FUNC enum with M_MUL=2'h0, M_MULH=2'h1, M_MULHSU=2'h2, M_MULHU=2'h3.
- One sub-module, mult_stage: a single pipeline stage carrying valid, func, partial sum and shifted operands. mult instantiates NUM_STAGES copies in a generate loop, plus the operand-extension and slice-select logic.

Test Plan:
- MUL, with a start pulse for each pair: 0*0 -> 0; 1*0 -> 0; 0*1 -> 0; 3*4 -> 12; 2*15 -> 30; 15*2 -> 30; 30*30 -> 900. Each result appears NUM_STAGES cycles after its start with done high.
- rs1=0xFF123456, rs2=0xFFFFF888:
  - MUL -> 0xF0091DB0
  - MULH -> 0x00000006
  - MULHU -> 0xFF122CE4
  - MULHSU -> 0xFF12345C
- rs1=0xC0000000, rs2=4: MUL -> 0; MULH -> 0xFFFFFFFF; MULHU -> 3; MULHSU -> 0xFFFFFFFF. Swapped operands (rs1=4, rs2=0xC0000000): MUL -> 0; MULH -> 0xFFFFFFFF; MULHU -> 3; MULHSU -> 3.
- 10 random operand pairs per func, issued back-to-back on consecutive cycles -> each result matches a 64-bit behavioural model. done pulses on consecutive cycles, in issue order.
- Assert reset low while 2 operations are in flight -> done=0 and result=0 immediately, and no later done pulse. A start after reset release completes normally.
- MULT_OUTPUT_REG_EN defined: repeat the 3*4 case -> 12 appears with latency NUM_STAGES+1.
